data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory port. It services the requests the CPU core issues in stage 3: address, store data, transfer size, and read/write enables.
- Provides a word-organised RAM with byte-lane writes and a same-cycle combinational read path, because the core consumes MEM_data in the same cycle it issues the load.
- Also decodes a small MMIO window containing an output FIFO (drained by a valid/ready port), a status register and a free-running cycle counter.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; byte range 0 .. 4*DEPTH_WORDS-1.
- FIFO_DEPTH, 4, entries in the MMIO output FIFO; power of two, >= 2.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the MMIO window (64 KiB, addr[31:16] match).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- MEM_addr  in  32  byte address; meaningful only while MEM_rd_en or MEM_wr_en is high.
- MEM_WR_out  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MEM_type  in  3  size: [1:0] 00 byte, 01 half, 10 word, 11 reserved; [2] ignored (core sign/zero-extends).
- MEM_rd_en  in  1  load request this cycle.
- MEM_wr_en  in  1  store request this cycle.
- MEM_data  out  32  load data, right-justified, upper bits zero; combinational.
- out_data  out  32  FIFO head entry.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts head when out_valid & out_ready at the rising edge.
- err_flag  out  1  sticky access-error flag.

Behaviour:
- Reset (synchronous, with rst high at the edge):
  - FIFO emptied: out_valid=0, out_data=0.
  - Cycle counter = 0, err_flag = 0, overflow = 0.
  - RAM contents are not cleared.
  - MEM_data = 0 while rst is high.
  - Any store presented in a reset cycle is discarded.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - A misaligned access or type 11 is an error: store suppressed, load returns 0, err_flag set at next edge.
- RAM region, MEM_addr < 4*DEPTH_WORDS:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store: at the edge, write only the lane(s) selected by addr[1:0] and size, with data shifted left by 8*addr[1:0]; other bytes are preserved.
  - Load: MEM_data = selected lane(s) shifted down to bit 0, zero-filled above. Zero latency.
  - Same-cycle load and store: MEM_data returns the old contents (read-before-write). Writes become visible the next cycle.
- Neither RAM nor MMIO: load returns 0, store is ignored, err_flag is set.
- MMIO registers (offset from MMIO_BASE):
  - 0x0 FIFO_DATA: store pushes the zero-extended right-justified data (byte/half/word). A load returns 0.
  - 0x4 STATUS: loads return {24'b0, overflow, full, empty, err_flag, count[3:0]}. A store of any value clears overflow and err_flag.
  - 0x8 CYCLES: loads return the counter, which increments every non-reset cycle and wraps 0xFFFF_FFFF -> 0. Stores are ignored.
  - Other offsets: loads return 0, stores are ignored; no error.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide. count = wptr - rptr.
  - Push when full and no pop in the same cycle: data dropped, overflow set (sticky).
  - Push and pop in the same cycle: both occur. When full, count stays full and the push is accepted.
  - Push and pop in the same cycle when empty: push only, because out_valid was 0.
  - out_data is the registered head; the new head is visible the cycle after a pop.
- MEM_rd_en and MEM_wr_en both high: treated as store; MEM_data still shows the read value.
- Error flag priority: when a STATUS clear and a new error occur in the same cycle, the new error wins (err_flag=1).

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD;
  - MMIO offsets OFF_FIFO / OFF_STATUS / OFF_CYCLES;
  - STATUS bit positions.
- Sub-module mmio_out_fifo (parameter FIFO_DEPTH; push/data/full, pop/head/valid, count, overflow). The top holds the RAM, lane steering, address decode and counter.

Test Plan:
- Byte lanes: store word 0x11223344 at 0x10, then store byte 0xAA at 0x12.
  - Load word 0x10 -> 0x11AA3344.
  - Load half 0x12 -> 0x000011AA.
  - Load byte 0x13 -> 0x00000011.
- Misalign: store half at 0x21 with data 0xBEEF.
  - Word at 0x20 is unchanged.
  - err_flag=1 next cycle.
  - Load half 0x21 returns 0.
  - Store to STATUS clears err_flag.
- FIFO fill: with out_ready=0, push 5 words 1..5 to FIFO_DEPTH=4.
  - STATUS = full=1, overflow=1, count=4.
  - Raising out_ready drains 1,2,3,4 on consecutive cycles; out_valid then drops.
- Full push+pop: with FIFO full, push 9 while out_ready=1.
  - Head 1 pops, 9 is accepted, count stays 4, overflow unchanged.
- Cycle counter: deassert reset and load CYCLES after N cycles -> N.
  - Force the counter to 0xFFFFFFFF (via a hierarchical deposit) -> next value 0.
- Reset mid-operation: assert rst for one cycle with FIFO count=3 and a store pending.
  - Next cycle: out_valid=0, counter=0, err_flag=0.
  - RAM retains prior data; the pending store is not written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: sizes, MMIO map, STATUS layout.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [15:0] OFF_FIFO   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLES = 16'h0008;

    localparam int unsigned ST_OVF_BIT   = 7;
    localparam int unsigned ST_FULL_BIT  = 6;
    localparam int unsigned ST_EMPTY_BIT = 5;
    localparam int unsigned ST_ERR_BIT   = 4;
    localparam int unsigned ST_CNT_LSB   = 0;

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] ofs);
        case (sz)
            SZ_BYTE: lane_mask = 4'b0001 << ofs;
            SZ_HALF: lane_mask = 4'b0011 << ofs;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Keep only the low bytes a transfer of this size carries, zero above.
    function automatic logic [31:0] size_trim(input logic [1:0] sz, input logic [31:0] v);
        case (sz)
            SZ_BYTE: size_trim = {24'b0, v[7:0]};
            SZ_HALF: size_trim = {16'b0, v[15:0]};
            default: size_trim = v;
        endcase
    endfunction

endpackage

// File: rtl/mmio_out_fifo.sv
// Output FIFO behind the MMIO FIFO_DATA register, drained by a valid/ready sink.
module mmio_out_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [31:0]                 push_data,
    input  logic                        pop_req,
    input  logic                        ovf_clr,
    output logic                        full,
    output logic                        valid,
    output logic [31:0]                 head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [31:0]   head_q;
    logic          ovf_q;

    logic [PW-1:0] count_c;
    logic          empty_c;
    logic          full_c;
    logic          pop_c;
    logic          push_ok_c;
    logic          drop_c;
    logic [AW-1:0] next_ridx_c;
    logic [31:0]   head_d;

    // Occupancy and handshake qualification; a pop frees a slot for a same-cycle push.
    always_comb begin
        count_c     = wptr_q - rptr_q;
        empty_c     = (count_c == '0);
        full_c      = (count_c == PW'(FIFO_DEPTH));
        pop_c       = pop_req & ~empty_c;
        push_ok_c   = push & (~full_c | pop_c);
        drop_c      = push & ~push_ok_c;
        next_ridx_c = AW'(rptr_q[AW-1:0] + AW'(1));
    end

    // Next registered head: successor entry, bypassed push data, or hold.
    always_comb begin
        head_d = head_q;
        if (pop_c) begin
            if (count_c > PW'(1)) begin
                head_d = mem[next_ridx_c];
            end else if (push_ok_c) begin
                head_d = push_data;
            end else begin
                head_d = '0;
            end
        end else if (empty_c && push_ok_c) begin
            head_d = push_data;
        end
    end

    // Entry storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_c) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointers, head register and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_q + PW'(push_ok_c);
            rptr_q <= rptr_q + PW'(pop_c);
            head_q <= head_d;
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign full     = full_c;
    assign valid    = ~empty_c;
    assign head     = head_q;
    assign count    = count_c;
    assign overflow = ovf_q;

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: byte-lane RAM with zero-latency loads plus an MMIO window.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_flag
);

    localparam int unsigned IW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] cycles_q;
    logic        err_q;

    logic [1:0]    sz_c;
    logic [1:0]    ofs_c;
    logic [IW-1:0] widx_c;
    logic [15:0]   moff_c;
    logic          in_ram_c;
    logic          in_mmio_c;
    logic          misalign_c;
    logic          access_c;
    logic          bad_c;
    logic          ok_c;
    logic          ram_we_c;
    logic          fifo_push_c;
    logic          stat_clr_c;
    logic [3:0]    be_c;
    logic [31:0]   wsh_c;
    logic [31:0]   st_ext_c;
    logic [31:0]   ram_rd_c;
    logic [31:0]   mmio_rd_c;
    logic [31:0]   status_c;

    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          fifo_ovf;
    logic          unused_type_hi;

    // The sign/zero-extension hint is handled by the core.
    assign unused_type_hi = MEM_type[2];

    // Address decode, alignment check and write qualification.
    always_comb begin
        sz_c        = MEM_type[1:0];
        ofs_c       = MEM_addr[1:0];
        widx_c      = MEM_addr[IW+1:2];
        moff_c      = MEM_addr[15:0];
        in_ram_c    = (MEM_addr < RAM_BYTES);
        in_mmio_c   = ~in_ram_c && (MEM_addr[31:16] == MMIO_BASE[31:16]);
        misalign_c  = (sz_c == 2'b11)
                   || ((sz_c == SZ_HALF) && ofs_c[0])
                   || ((sz_c == SZ_WORD) && (ofs_c != 2'b00));
        access_c    = MEM_rd_en | MEM_wr_en;
        bad_c       = access_c & (misalign_c | ~(in_ram_c | in_mmio_c));
        ok_c        = access_c & ~bad_c;
        ram_we_c    = ~rst & MEM_wr_en & ok_c & in_ram_c;
        fifo_push_c = ~rst & MEM_wr_en & ok_c & in_mmio_c & (moff_c == OFF_FIFO);
        stat_clr_c  = ~rst & MEM_wr_en & ok_c & in_mmio_c & (moff_c == OFF_STATUS);
        be_c        = lane_mask(sz_c, ofs_c);
        wsh_c       = MEM_WR_out << {ofs_c, 3'b000};
        st_ext_c    = size_trim(sz_c, MEM_WR_out);
    end

    // Zero-latency read path; a same-cycle store is not yet visible here.
    always_comb begin
        status_c = '0;
        status_c[ST_OVF_BIT]            = fifo_ovf;
        status_c[ST_FULL_BIT]           = fifo_full;
        status_c[ST_EMPTY_BIT]          = ~out_valid;
        status_c[ST_ERR_BIT]            = err_q;
        status_c[ST_CNT_LSB +: 4]       = 4'(fifo_count);
        ram_rd_c  = size_trim(sz_c, ram[widx_c] >> {ofs_c, 3'b000});
        mmio_rd_c = '0;
        case (moff_c)
            OFF_STATUS: mmio_rd_c = size_trim(sz_c, status_c);
            OFF_CYCLES: mmio_rd_c = size_trim(sz_c, cycles_q);
            default:    mmio_rd_c = '0;
        endcase
        MEM_data = '0;
        if (!rst && MEM_rd_en && ok_c) begin
            MEM_data = in_ram_c ? ram_rd_c : mmio_rd_c;
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    ram[widx_c][8*b +: 8] <= wsh_c[8*b +: 8];
                end
            end
        end
    end

    // Free-running cycle counter and sticky error flag; a new error beats a clear.
    always_ff @(posedge CLK) begin
        if (rst) begin
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (bad_c) begin
                err_q <= 1'b1;
            end else if (stat_clr_c) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_flag = err_q;

    mmio_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (rst),
        .push      (fifo_push_c),
        .push_data (st_ext_c),
        .pop_req   (out_ready),
        .ovf_clr   (stat_clr_c),
        .full      (fifo_full),
        .valid     (out_valid),
        .head      (out_data),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

endmodule
